l2c_lru_ctl: RTL and testbench

Parametrised, stateful LRU replacement controller for the L2 cache tag pipeline. It holds per-set age counters and valid bits internally, and accepts HIT, REPLACE and INVALIDATE requests over a valid/ready handshake. For REPLACE it returns the victim way two cycles after acceptance. It supersedes the fixed 8-way combinational LRU stage by owning the LRU state, so the tag array no longer stores or returns ages.

---
 rtl/l2c_lru_pkg.sv | 35 +++
 rtl/l2c_lru_upd.sv | 105 ++++++++++
 rtl/l2c_lru_ctl.sv | 193 +++++++++++++++++++
 tb/tb_l2c_lru_ctl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/l2c_lru_pkg.sv
// Shared types and helpers for the L2 cache LRU replacement controller:
// request op encodings, controller FSM states, the set-state record and clog2.
package l2c_lru_pkg;

  typedef enum logic [1:0] {
    LRU_NOP  = 2'b00,
    LRU_HIT  = 2'b01,
    LRU_REPL = 2'b10,
    LRU_INV  = 2'b11
  } lru_op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } lru_fsm_e;

  localparam int LRU_MAX_WAYS  = 16;
  localparam int LRU_MAX_AGE_W = 4;

  // Full per-set state at the widest supported associativity (16 ways, 4-bit ages).
  typedef struct packed {
    logic [LRU_MAX_WAYS-1:0][LRU_MAX_AGE_W-1:0] age;
    logic [LRU_MAX_WAYS-1:0]                    vld;
  } lru_set_t;

  function automatic int lru_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/l2c_lru_upd.sv
// Combinational one-set LRU update: next ages/valids, victim way and evict flag
// for HIT, REPLACE, INVALIDATE and NOP, with writeback suppressed when disabled.
module l2c_lru_upd
  import l2c_lru_pkg::*;
#(
  parameter  int NWAYS = 8,
  localparam int WAY_W = lru_clog2(NWAYS)
) (
  input  logic [NWAYS*WAY_W-1:0] i_age,
  input  logic [NWAYS-1:0]       i_vld,
  input  logic [1:0]             i_op,
  input  logic [WAY_W-1:0]       i_way,
  input  logic                   i_en,
  output logic [NWAYS*WAY_W-1:0] o_age,
  output logic [NWAYS-1:0]       o_vld,
  output logic [WAY_W-1:0]       o_victim,
  output logic                   o_evict
);

  logic [WAY_W-1:0] age    [NWAYS];
  logic [WAY_W-1:0] age_nx [NWAYS];
  logic [NWAYS-1:0] vld_nx;
  logic [WAY_W-1:0] max_way;
  logic [WAY_W-1:0] inv_way;
  logic             inv_found;
  logic [WAY_W-1:0] victim;

  function automatic logic [WAY_W-1:0] sat_inc(input logic [WAY_W-1:0] a);
    return (a == {WAY_W{1'b1}}) ? a : a + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NWAYS; i++) age[i] = i_age[i*WAY_W +: WAY_W];
  end

  // Heap-ordered max tree: leaves NWAYS-1.. hold ways 0..; strict compare keeps the lower-index child on ties.
  always_comb begin
    logic [WAY_W-1:0] t_age [2*NWAYS-1];
    logic [WAY_W-1:0] t_idx [2*NWAYS-1];
    for (int i = 0; i < NWAYS; i++) begin
      t_age[NWAYS-1+i] = age[i];
      t_idx[NWAYS-1+i] = WAY_W'(i);
    end
    for (int n = NWAYS - 2; n >= 0; n--) begin
      if (t_age[2*n+2] > t_age[2*n+1]) begin
        t_age[n] = t_age[2*n+2];
        t_idx[n] = t_idx[2*n+2];
      end else begin
        t_age[n] = t_age[2*n+1];
        t_idx[n] = t_idx[2*n+1];
      end
    end
    max_way = t_idx[0];
  end

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (!i_vld[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
    victim = inv_found ? inv_way : max_way;
  end

  always_comb begin
    age_nx = age;
    vld_nx = i_vld;
    if (i_en) begin
      case (lru_op_e'(i_op))
        LRU_HIT: begin
          if (i_vld[i_way]) begin
            for (int i = 0; i < NWAYS; i++) begin
              if (i_vld[i] && (age[i] < age[i_way])) age_nx[i] = age[i] + 1'b1;
            end
            age_nx[i_way] = '0;
          end
        end
        LRU_REPL: begin
          for (int i = 0; i < NWAYS; i++) begin
            if (i_vld[i] && (WAY_W'(i) != victim)) age_nx[i] = sat_inc(age[i]);
          end
          age_nx[victim] = '0;
          vld_nx[victim] = 1'b1;
        end
        LRU_INV: begin
          age_nx[i_way] = '0;
          vld_nx[i_way] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NWAYS; i++) o_age[i*WAY_W +: WAY_W] = age_nx[i];
  end

  assign o_vld    = vld_nx;
  assign o_victim = victim;
  assign o_evict  = (i_op == LRU_REPL) && !inv_found;

endmodule

// File: rtl/l2c_lru_ctl.sv
// L2 cache LRU replacement controller: owns per-set ages/valids, clears them after reset,
// and serves HIT/REPLACE/INVALIDATE requests. Define L2C_LRU_FWD_EN to forward same-set updates.
module l2c_lru_ctl
  import l2c_lru_pkg::*;
#(
  parameter  int NWAYS = 8,
  parameter  int NSETS = 256,
  localparam int WAY_W = lru_clog2(NWAYS),
  localparam int SET_W = lru_clog2(NSETS),
  localparam int AGE_W = NWAYS * WAY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_lru_enable,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_op,
  input  logic [SET_W-1:0] i_req_set,
  input  logic [WAY_W-1:0] i_req_way,
  output logic             o_rsp_valid,
  output logic [WAY_W-1:0] o_rsp_way,
  output logic             o_rsp_evict,
  output logic [SET_W-1:0] o_rsp_set,
  output logic             o_init_done
);

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NSETS - 1);

  lru_fsm_e         fsm_q, fsm_d;
  logic [SET_W-1:0] init_cnt_q, init_cnt_d;
  logic             init_done_q, init_done_d;

  logic             s1_vld_q, s1_vld_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [SET_W-1:0] s1_set_q, s1_set_d;
  logic [WAY_W-1:0] s1_way_q, s1_way_d;
  logic             s1_en_q, s1_en_d;
  logic [AGE_W-1:0] s1_age_q, s1_age_d;
  logic [NWAYS-1:0] s1_v_q, s1_v_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [WAY_W-1:0] rsp_way_q, rsp_way_d;
  logic             rsp_evict_q, rsp_evict_d;
  logic [SET_W-1:0] rsp_set_q, rsp_set_d;

  logic [AGE_W-1:0] age_q [NSETS];
  logic [NWAYS-1:0] v_q   [NSETS];

  logic             wr_en;
  logic [SET_W-1:0] wr_set;
  logic [AGE_W-1:0] wr_age;
  logic [NWAYS-1:0] wr_v;

  logic             run;
  logic             same_set;
  logic             fwd_hit;
  logic             accept;
  logic [AGE_W-1:0] upd_age;
  logic [NWAYS-1:0] upd_v;
  logic [WAY_W-1:0] upd_victim;
  logic             upd_evict;

  assign run      = (fsm_q == ST_RUN);
  assign same_set = s1_vld_q && (s1_set_q == i_req_set);

`ifdef L2C_LRU_FWD_EN
  assign o_req_ready = run;
  assign fwd_hit     = same_set;
`else
  // A same-set request would read the array before S1 writes it back, so hold it one cycle.
  assign o_req_ready = run && !same_set;
  assign fwd_hit     = 1'b0;
`endif

  assign accept = i_req_valid && o_req_ready;

  l2c_lru_upd #(
    .NWAYS(NWAYS)
  ) u_upd (
    .i_age   (s1_age_q),
    .i_vld   (s1_v_q),
    .i_op    (s1_op_q),
    .i_way   (s1_way_q),
    .i_en    (s1_en_q),
    .o_age   (upd_age),
    .o_vld   (upd_v),
    .o_victim(upd_victim),
    .o_evict (upd_evict)
  );

  // Capture into S1: request fields plus the set state, forwarded from S1 when enabled.
  always_comb begin
    s1_vld_d = accept;
    s1_op_d  = s1_op_q;
    s1_set_d = s1_set_q;
    s1_way_d = s1_way_q;
    s1_en_d  = s1_en_q;
    s1_age_d = s1_age_q;
    s1_v_d   = s1_v_q;
    if (accept) begin
      s1_op_d  = i_req_op;
      s1_set_d = i_req_set;
      s1_way_d = i_req_way;
      s1_en_d  = i_lru_enable;
      s1_age_d = fwd_hit ? upd_age : age_q[i_req_set];
      s1_v_d   = fwd_hit ? upd_v   : v_q[i_req_set];
    end
  end

  // S1 -> response registers and state writeback on the same edge.
  always_comb begin
    rsp_valid_d = s1_vld_q;
    rsp_way_d   = rsp_way_q;
    rsp_evict_d = rsp_evict_q;
    rsp_set_d   = rsp_set_q;
    if (s1_vld_q) begin
      rsp_way_d   = (s1_op_q == LRU_REPL) ? upd_victim : s1_way_q;
      rsp_evict_d = upd_evict;
      rsp_set_d   = s1_set_q;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    wr_en       = 1'b0;
    wr_set      = init_cnt_q;
    wr_age      = '0;
    wr_v        = '0;
    case (fsm_q)
      ST_INIT: begin
        wr_en      = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_SET) begin
          fsm_d       = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (s1_vld_q && s1_en_q) begin
          wr_en  = 1'b1;
          wr_set = s1_set_q;
          wr_age = upd_age;
          wr_v   = upd_v;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
      rsp_evict_q <= 1'b0;
      rsp_set_q   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      s1_vld_q    <= s1_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_way_q   <= rsp_way_d;
      rsp_evict_q <= rsp_evict_d;
      rsp_set_q   <= rsp_set_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_op_q  <= s1_op_d;
    s1_set_q <= s1_set_d;
    s1_way_q <= s1_way_d;
    s1_en_q  <= s1_en_d;
    s1_age_q <= s1_age_d;
    s1_v_q   <= s1_v_d;
    if (wr_en) begin
      age_q[wr_set] <= wr_age;
      v_q[wr_set]   <= wr_v;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_way   = rsp_way_q;
  assign o_rsp_evict = rsp_evict_q;
  assign o_rsp_set   = rsp_set_q;
  assign o_init_done = init_done_q;

endmodule

// File: tb/tb_l2c_lru_ctl.sv
// Directed self-checking bench for l2c_lru_ctl (8 ways, 256 sets); stall expectations
// follow L2C_LRU_FWD_EN.
module tb_l2c_lru_ctl;
  import l2c_lru_pkg::*;

  localparam int NWAYS = 8;
  localparam int NSETS = 256;
  localparam int WAY_W = 3;
  localparam int SET_W = 8;

`ifdef L2C_LRU_FWD_EN
  localparam int EXP_STALLS = 0;
`else
  localparam int EXP_STALLS = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_lru_enable = 1'b1;
  logic             i_req_valid = 1'b0;
  logic             o_req_ready;
  logic [1:0]       i_req_op = 2'b00;
  logic [SET_W-1:0] i_req_set = '0;
  logic [WAY_W-1:0] i_req_way = '0;
  logic             o_rsp_valid;
  logic [WAY_W-1:0] o_rsp_way;
  logic             o_rsp_evict;
  logic [SET_W-1:0] o_rsp_set;
  logic             o_init_done;

  int n_chk  = 0;
  int n_fail = 0;

  l2c_lru_ctl #(
    .NWAYS(NWAYS),
    .NSETS(NSETS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_lru_enable(i_lru_enable),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_set   (i_req_set),
    .i_req_way   (i_req_way),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_way   (o_rsp_way),
    .o_rsp_evict (o_rsp_evict),
    .o_rsp_set   (o_rsp_set),
    .o_init_done (o_init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Call right after releasing rst_n on a negedge.
  task automatic wait_init();
    int early;
    early = 0;
    for (int k = 1; k < NSETS; k++) begin
      @(negedge clk);
      #1;
      if (o_req_ready || o_init_done || o_rsp_valid) early++;
    end
    chk("init_early_activity", early, 0);
    @(negedge clk);
    #1;
    chk("init_ready", o_req_ready, 1);
    chk("init_done", o_init_done, 1);
  endtask

  task automatic do_req(input logic [1:0] op, input int set, input int way,
                        output int rway, output int revict, output int rset);
    int cyc;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_set   = SET_W'(set);
    i_req_way   = WAY_W'(way);
    #1;
    cyc = 0;
    while (!o_req_ready && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("req_ready", o_req_ready, 1);
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rsp_valid_latency", o_rsp_valid, 1);
    rway   = o_rsp_way;
    revict = o_rsp_evict;
    rset   = o_rsp_set;
  endtask

  initial begin
    int w, e, s;
    int sent, stalls, nrsp, seen;
    int rsp_w [4];

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", o_req_ready, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_way", o_rsp_way, 0);
    chk("rst_rsp_evict", o_rsp_evict, 0);
    chk("rst_rsp_set", o_rsp_set, 0);
    chk("rst_init_done", o_init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();

    do_req(LRU_REPL, 5, 0, w, e, s);
    chk("repl5_way", w, 0);
    chk("repl5_evict", e, 0);
    chk("repl5_set", s, 5);

    for (int k = 0; k < NWAYS; k++) begin
      do_req(LRU_REPL, 3, 0, w, e, s);
      chk("fill3_way", w, k);
      chk("fill3_evict", e, 0);
    end
    do_req(LRU_REPL, 3, 0, w, e, s);
    chk("full3_way", w, 0);
    chk("full3_evict", e, 1);

    // HIT on the oldest way of a full set; LRU order becomes 1..7 then 0.
    for (int k = 0; k < NWAYS; k++) begin
      do_req(LRU_REPL, 4, 0, w, e, s);
      chk("fill4_way", w, k);
    end
    do_req(LRU_HIT, 4, 0, w, e, s);
    chk("hit4_way", w, 0);
    chk("hit4_set", s, 4);
    for (int k = 0; k < NWAYS; k++) begin
      do_req(LRU_REPL, 4, 0, w, e, s);
      chk("lru4_way", w, (k + 1) % NWAYS);
      chk("lru4_evict", e, 1);
    end

    for (int k = 0; k < NWAYS; k++) begin
      do_req(LRU_REPL, 6, 0, w, e, s);
      chk("fill6_way", w, k);
    end
    do_req(LRU_INV, 6, 6, w, e, s);
    chk("inv6_way", w, 6);
    do_req(LRU_REPL, 6, 0, w, e, s);
    chk("inv6_repl_way", w, 6);
    chk("inv6_repl_evict", e, 0);

    // Back-to-back REPLACE on set 9.
    sent = 0;
    stalls = 0;
    nrsp = 0;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_op    = LRU_REPL;
    i_req_set   = 8'd9;
    i_req_way   = '0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (o_rsp_valid && nrsp < 4) begin
        rsp_w[nrsp] = o_rsp_way;
        nrsp++;
      end
      if (i_req_valid) begin
        if (o_req_ready) sent++;
        else stalls++;
      end
      @(negedge clk);
      if (sent == 2) i_req_valid = 1'b0;
    end
    chk("b2b_sent", sent, 2);
    chk("b2b_stalls", stalls, EXP_STALLS);
    chk("b2b_nrsp", nrsp, 2);
    chk("b2b_way0", rsp_w[0], 0);
    chk("b2b_way1", rsp_w[1], 1);

    i_lru_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_req(LRU_REPL, 20, 0, w, e, s);
      chk("dis_way", w, 0);
      chk("dis_evict", e, 0);
    end
    i_lru_enable = 1'b1;
    do_req(LRU_REPL, 20, 0, w, e, s);
    chk("dis_after_way", w, 0);

    // Reset while a request sits in S1.
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_op    = LRU_REPL;
    i_req_set   = 8'd30;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", o_rsp_valid, 0);
    chk("midrst_ready", o_req_ready, 0);
    i_req_valid = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (o_rsp_valid) seen++;
    end
    chk("midrst_no_rsp", seen, 0);
    chk("midrst_init_done", o_init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    do_req(LRU_REPL, 3, 0, w, e, s);
    chk("postrst3_way", w, 0);
    chk("postrst3_evict", e, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
